pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Sequencing controller for the five-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB). It generates the active-low stage enables, the PC write strobe, the ID_EX bubble and the IF_ID flush. It resolves three conditions: load-use hazards, multi-cycle data-memory accesses and taken branches. It also counts stall cycles and flags a memory-access timeout.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum cycles spent in MEM_WAIT before the error is raised (range 1..255).
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  pipeline clock. Controller state updates on posedge. Pipeline registers capture on negedge.
- reset_n  in  1  asynchronous, active-low reset.
- id_ex_mem_read  in  1  instruction in EX is a load.
- id_ex_rt  in  5  destination register of the load in EX.
- if_id_rs  in  5  source register rs of the instruction in ID.
- if_id_rt  in  5  source register rt of the instruction in ID.
- mem_req  in  1  MEM stage is issuing a data-memory access this cycle.
- mem_ack  in  1  data memory has completed the access.
- branch_taken  in  1  branch resolved taken in EX.
- pc_write  out  1  1 = PC loads its next value.
- IF_ID_enable  out  1  per-stage enable; 0 = stage captures, 1 = stage holds/invalid.
- ID_EX_enable  out  1  per-stage enable; same polarity as IF_ID_enable.
- EX_MEM_enable  out  1  per-stage enable; same polarity as IF_ID_enable.
- MEM_WB_enable  out  1  per-stage enable; same polarity as IF_ID_enable.
- id_ex_bubble  out  1  1 = ID_EX loads a NOP (all control flags 0).
- if_id_flush  out  1  1 = IF_ID loads a NOP.
- mem_timeout_err  out  1  sticky timeout flag.
- stall_count  out  CNT_W  saturating count of cycles with pc_write=0.

## Operation
- States: RUN, MEM_WAIT, ERROR. The state is held in registers.
- Outputs are combinational from the state and the inputs (Mealy).
- "Advance" means:
  - pc_write=1, all four enables=0, id_ex_bubble=0, if_id_flush=0.
- "Freeze" means:
  - pc_write=0, all four enables=1, id_ex_bubble=0, if_id_flush=0.
- Load-use hazard (luh) is asserted when all of these hold:
  - id_ex_mem_read=1;
  - id_ex_rt≠0;
  - id_ex_rt equals if_id_rs or if_id_rt.
- RUN behaviour, in priority order (highest first):
  1. mem_req=1 and mem_ack=0: Freeze. Next state MEM_WAIT, wait_cnt←1.
  2. branch_taken=1: Advance, with if_id_flush=1 and id_ex_bubble=1. Stay in RUN. Branch outranks luh because the hazarding instruction is squashed.
  3. luh: pc_write=0, IF_ID_enable=1, id_ex_bubble=1, ID_EX/EX_MEM/MEM_WB enables=0. Stay in RUN. The hazard clears by itself one cycle later.
  4. Otherwise: Advance.
- MEM_WAIT behaviour:
  - mem_ack=1: Advance and go to RUN. The ack is honoured even when wait_cnt=MEM_TIMEOUT.
  - mem_ack=0 and wait_cnt<MEM_TIMEOUT: Freeze, wait_cnt+1.
  - mem_ack=0 and wait_cnt=MEM_TIMEOUT: Freeze, go to ERROR, set mem_timeout_err.
  - branch_taken and luh are ignored in this state.
- ERROR behaviour: Freeze permanently, mem_timeout_err=1. The only exit is reset.
- stall_count:
  - Increments on each posedge where pc_write=0 and state≠ERROR.
  - Saturates at 2^CNT_W−1 and never wraps.
- wait_cnt is 8 bits wide and is cleared whenever the state is RUN.

## Timing
- Reset (reset_n=0, asynchronous):
  - state=RUN, wait_cnt=0, stall_count=0, mem_timeout_err=0.
  - Outputs are forced to Freeze (pc_write=0, enables=1, bubble=0, flush=0) while reset_n=0, overriding the state decode.
  - Reset asserted mid-MEM_WAIT or in ERROR returns to RUN immediately.
- After reset release, outputs follow the RUN decode with no latency.
- Output latency is zero cycles from the inputs (combinational). Outputs must be stable before the negedge at which the pipeline registers capture.
- A load-use stall costs exactly 1 cycle.
- A memory access acked after N wait cycles costs N frozen cycles. The ack cycle itself advances.
- Timeout: ERROR is entered on the posedge that ends the MEM_TIMEOUT-th frozen MEM_WAIT cycle with no ack. In total, MEM_TIMEOUT+1 frozen cycles are counted, including the entry cycle.

## Test plan
- Reset: hold reset_n=0 for 3 cycles with random inputs. Required: pc_write=0, all enables=1, stall_count=0, mem_timeout_err=0. After release with idle inputs: Advance on the first cycle.
- Load-use: id_ex_mem_read=1, id_ex_rt=5, if_id_rs=5 for one cycle. Required: pc_write=0, IF_ID_enable=1, id_ex_bubble=1, ID_EX_enable=0, stall_count=1. Repeat with id_ex_rt=0: required Advance, no stall.
- Branch versus load-use: branch_taken=1 and luh in the same cycle. Required: pc_write=1, if_id_flush=1, id_ex_bubble=1, stall_count unchanged.
- Memory wait: mem_req=1 with mem_ack low for 3 cycles, then high. Required: 3 Freeze cycles, then Advance and return to RUN; stall_count=3.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ack held 0. Required: ERROR and mem_timeout_err=1 after 5 frozen cycles, held indefinitely. A later mem_ack=1 has no effect; only reset_n=0 clears it.
- Timeout race: mem_ack=1 in the same cycle as wait_cnt=MEM_TIMEOUT. Required: Advance and RUN, mem_timeout_err=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: stage enables, PC write, bubble/flush.
// Handles load-use, multi-cycle memory waits, taken branches, timeout.
//
// Ports:
//   clk, reset_n           clock, async active-low reset
//   id_ex_mem_read/rt      load in EX and its destination register
//   if_id_rs/rt            source registers of the instruction in ID
//   mem_req, mem_ack       data-memory access request / completion
//   branch_taken           branch resolved taken in EX
//   pc_write               1 = PC loads next value
//   *_enable               active-low stage enables (1 = hold)
//   id_ex_bubble           ID_EX loads a NOP
//   if_id_flush            IF_ID loads a NOP
//   mem_timeout_err        sticky memory timeout flag
//   stall_count            saturating count of stalled cycles
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             IF_ID_enable,
  output logic             ID_EX_enable,
  output logic             EX_MEM_enable,
  output logic             MEM_WB_enable,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;
  logic [3:0] stage_en;
  logic       luh;

  // {IF_ID, ID_EX, EX_MEM, MEM_WB}
  assign {IF_ID_enable, ID_EX_enable,
          EX_MEM_enable, MEM_WB_enable} = stage_en;

  // Register 0 is hardwired, so a load to it never hazards.
  assign luh = id_ex_mem_read
            && (id_ex_rt != 5'd0)
            && ((id_ex_rt == if_id_rs)
             || (id_ex_rt == if_id_rt));

  always_comb begin
    pc_write     = 1'b0;
    stage_en     = 4'b1111;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    state_nxt    = state;
    wait_nxt     = wait_cnt;
    // While in reset the decode is bypassed and outputs stay frozen.
    if (reset_n) begin
      unique case (state)
        RUN: begin
          wait_nxt = 8'd0;
          if (mem_req && !mem_ack) begin
            state_nxt = MEM_WAIT;
            wait_nxt  = 8'd1;
          end else if (branch_taken) begin
            // Squashes the hazarding instruction too.
            pc_write     = 1'b1;
            stage_en     = 4'b0000;
            id_ex_bubble = 1'b1;
            if_id_flush  = 1'b1;
          end else if (luh) begin
            stage_en     = 4'b1000;
            id_ex_bubble = 1'b1;
          end else begin
            pc_write = 1'b1;
            stage_en = 4'b0000;
          end
        end
        MEM_WAIT: begin
          // An ack wins even on the last allowed cycle.
          if (mem_ack) begin
            pc_write  = 1'b1;
            stage_en  = 4'b0000;
            state_nxt = RUN;
            wait_nxt  = 8'd0;
          end else if (wait_cnt < TMO) begin
            wait_nxt = wait_cnt + 8'd1;
          end else begin
            state_nxt = ERROR;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= RUN;
      wait_cnt        <= 8'd0;
      mem_timeout_err <= 1'b0;
      stall_count     <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (state_nxt == ERROR)
        mem_timeout_err <= 1'b1;
      if (!pc_write && state != ERROR
          && stall_count != CNT_MAX)
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule
